// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the parameterised register file:
// NZCV flag bit positions, default geometry and PC update source selection.
package reg_file_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_PC_STEP = 4;

    typedef enum logic [1:0] {
        PC_SRC_HOLD,
        PC_SRC_INC,
        PC_SRC_WR,
        PC_SRC_PCIN
    } pc_src_e;

    // Direct load beats a register-file write to the PC, which beats auto-increment.
    function automatic pc_src_e pc_src_sel(input logic loadpc, input logic wr_pc, input logic inc);
        pc_src_e src;
        if (loadpc) begin
            src = PC_SRC_PCIN;
        end else if (wr_pc) begin
            src = PC_SRC_WR;
        end else if (inc) begin
            src = PC_SRC_INC;
        end else begin
            src = PC_SRC_HOLD;
        end
        return src;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// Define RF_BYPASS_EN to forward same-cycle write data to a matching select.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
    input  logic [ADDR_W-1:0] sel_i,
    input  logic [ADDR_W-1:0] wr_sel_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_o
);

`ifdef RF_BYPASS_EN
    always_comb begin
        rd_o = regs_i[sel_i];
        if (wr_en_i && (sel_i == wr_sel_i)) begin
            rd_o = wr_data_i;
        end
    end
`else
    always_comb begin
        rd_o = regs_i[sel_i];
    end

    logic unused_bypass;
    assign unused_bypass = ^{wr_en_i, wr_sel_i, wr_data_i};
`endif

endmodule

// File: rtl/reg_file_param.sv
// Register file with PC in the top register and an NZCV flag register.
// Define RF_BYPASS_EN to make reads and PCout reflect this cycle's writes.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int PC_STEP = DEF_PC_STEP
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] Rn_sel,
    input  logic [ADDR_W-1:0] Rm_sel,
    input  logic [ADDR_W-1:0] Rs_sel,
    input  logic [ADDR_W-1:0] Rd_sel,
    input  logic [DATA_W-1:0] in,
    input  logic              LOAD,
    input  logic [DATA_W-1:0] Pcin,
    input  logic              LOADPC,
    input  logic              PC_INC,
    input  logic [3:0]        FLAGS_IN,
    input  logic              FLAGS_LD,
    output logic [DATA_W-1:0] Rn,
    output logic [DATA_W-1:0] Rm,
    output logic [DATA_W-1:0] Rs,
    output logic [DATA_W-1:0] PCout,
    output logic [3:0]        FLAGS
);

    localparam int NREG   = 2**ADDR_W;
    localparam int PC_IDX = NREG - 1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [3:0]        flags_q;
    logic [3:0]        flags_d;
    logic              wr_pc;
    pc_src_e           pc_src;

    assign wr_pc  = LOAD && (Rd_sel == ADDR_W'(PC_IDX));
    assign pc_src = pc_src_sel(LOADPC, wr_pc, PC_INC);

    // The general write lands first; the PC case then overrides register NREG-1 only.
    always_comb begin
        regs_d = regs_q;
        if (LOAD) begin
            regs_d[Rd_sel] = in;
        end
        unique case (pc_src)
            PC_SRC_PCIN: regs_d[PC_IDX] = Pcin;
            PC_SRC_WR:   regs_d[PC_IDX] = in;
            PC_SRC_INC:  regs_d[PC_IDX] = regs_q[PC_IDX] + DATA_W'(PC_STEP);
            default:     ;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (FLAGS_LD) begin
            flags_d = FLAGS_IN;
        end
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            regs_q  <= '{default: '0};
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_rn (
        .regs_i   (regs_q),
        .sel_i    (Rn_sel),
        .wr_sel_i (Rd_sel),
        .wr_en_i  (LOAD),
        .wr_data_i(in),
        .rd_o     (Rn)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_rm (
        .regs_i   (regs_q),
        .sel_i    (Rm_sel),
        .wr_sel_i (Rd_sel),
        .wr_en_i  (LOAD),
        .wr_data_i(in),
        .rd_o     (Rm)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_rs (
        .regs_i   (regs_q),
        .sel_i    (Rs_sel),
        .wr_sel_i (Rd_sel),
        .wr_en_i  (LOAD),
        .wr_data_i(in),
        .rd_o     (Rs)
    );

`ifdef RF_BYPASS_EN
    assign PCout = regs_d[PC_IDX];
`else
    assign PCout = regs_q[PC_IDX];
`endif

    assign FLAGS = flags_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: vector table with a scoreboard queue,
// plus hand sequences for same-cycle forwarding and asynchronous reset.
module tb_reg_file_param;
    import reg_file_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NV = 16;

    logic          Clk = 1'b0;
    logic          RESET;
    logic [AW-1:0] Rn_sel, Rm_sel, Rs_sel, Rd_sel;
    logic [DW-1:0] in, Pcin;
    logic          LOAD, LOADPC, PC_INC, FLAGS_LD;
    logic [3:0]    FLAGS_IN;
    logic [DW-1:0] Rn, Rm, Rs, PCout;
    logic [3:0]    FLAGS;

    reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .PC_STEP(4)) dut (
        .Clk     (Clk),
        .RESET   (RESET),
        .Rn_sel  (Rn_sel),
        .Rm_sel  (Rm_sel),
        .Rs_sel  (Rs_sel),
        .Rd_sel  (Rd_sel),
        .in      (in),
        .LOAD    (LOAD),
        .Pcin    (Pcin),
        .LOADPC  (LOADPC),
        .PC_INC  (PC_INC),
        .FLAGS_IN(FLAGS_IN),
        .FLAGS_LD(FLAGS_LD),
        .Rn      (Rn),
        .Rm      (Rm),
        .Rs      (Rs),
        .PCout   (PCout),
        .FLAGS   (FLAGS)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          ld;
        logic [AW-1:0] rd;
        logic [DW-1:0] din;
        logic          lpc;
        logic [DW-1:0] pcin;
        logic          inc;
        logic          fld;
        logic [3:0]    fin;
        logic [AW-1:0] rn, rm, rs;
        logic [DW-1:0] ern, erm, ers, epc;
        logic [3:0]    efl;
    } vec_t;

    vec_t vecs [NV];
    vec_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_ctrl();
        LOAD     = 1'b0;
        LOADPC   = 1'b0;
        PC_INC   = 1'b0;
        FLAGS_LD = 1'b0;
    endtask

    function automatic vec_t mkv(
        input logic ld, input logic [AW-1:0] rd, input logic [DW-1:0] din,
        input logic lpc, input logic [DW-1:0] pcin, input logic inc,
        input logic fld, input logic [3:0] fin,
        input logic [AW-1:0] rn, input logic [AW-1:0] rm, input logic [AW-1:0] rs,
        input logic [DW-1:0] ern, input logic [DW-1:0] erm, input logic [DW-1:0] ers,
        input logic [DW-1:0] epc, input logic [3:0] efl);
        vec_t v;
        v.ld = ld; v.rd = rd; v.din = din; v.lpc = lpc; v.pcin = pcin; v.inc = inc;
        v.fld = fld; v.fin = fin; v.rn = rn; v.rm = rm; v.rs = rs;
        v.ern = ern; v.erm = erm; v.ers = ers; v.epc = epc; v.efl = efl;
        return v;
    endfunction

    initial begin
        vec_t      e;
        logic [3:0] f_nc;
        f_nc = 4'((1 << FLAG_N) | (1 << FLAG_C));

        //              ld rd  din           lpc pcin          inc fld fin    rn rm rs  ern           erm           ers           epc           efl
        vecs[0]  = mkv(0, 0,  0,            1, 32'h100,      0,  0, 4'h0,  0, 1, 2,  0,            0,            0,            32'h100,      4'h0);
        vecs[1]  = mkv(0, 0,  0,            0, 0,            1,  0, 4'h0,  0, 1, 2,  0,            0,            0,            32'h104,      4'h0);
        vecs[2]  = mkv(0, 0,  0,            0, 0,            1,  0, 4'h0,  0, 1, 2,  0,            0,            0,            32'h108,      4'h0);
        vecs[3]  = mkv(0, 0,  0,            0, 0,            1,  0, 4'h0,  0, 1, 2,  0,            0,            0,            32'h10C,      4'h0);
        vecs[4]  = mkv(1, 3,  32'hDEADBEEF, 0, 0,            0,  0, 4'h0,  3, 3, 3,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h10C,      4'h0);
        vecs[5]  = mkv(0, 0,  0,            0, 0,            0,  0, 4'h0,  0, 4, 15, 0,            0,            32'h10C,      32'h10C,      4'h0);
        vecs[6]  = mkv(1, 15, 32'h80,       1, 32'h40,       1,  0, 4'h0,  15, 3, 1, 32'h40,       32'hDEADBEEF, 0,            32'h40,       4'h0);
        vecs[7]  = mkv(1, 15, 32'h80,       0, 0,            1,  0, 4'h0,  15, 15, 0, 32'h80,      32'h80,       0,            32'h80,       4'h0);
        vecs[8]  = mkv(1, 2,  32'h55,       0, 0,            1,  0, 4'h0,  2, 15, 3, 32'h55,       32'h84,       32'hDEADBEEF, 32'h84,       4'h0);
        vecs[9]  = mkv(1, 7,  32'hA5A5,     1, 32'h200,      0,  0, 4'h0,  7, 2, 15, 32'hA5A5,     32'h55,       32'h200,      32'h200,      4'h0);
        vecs[10] = mkv(0, 0,  0,            1, 32'hFFFFFFFC, 0,  0, 4'h0,  15, 7, 3, 32'hFFFFFFFC, 32'hA5A5,     32'hDEADBEEF, 32'hFFFFFFFC, 4'h0);
        vecs[11] = mkv(0, 0,  0,            0, 0,            1,  0, 4'h0,  15, 0, 2, 0,            0,            32'h55,       0,            4'h0);
        vecs[12] = mkv(0, 0,  0,            0, 0,            0,  1, f_nc,  3, 7, 2,  32'hDEADBEEF, 32'hA5A5,     32'h55,       0,            4'b1010);
        vecs[13] = mkv(0, 0,  0,            0, 0,            0,  0, 4'h5,  3, 7, 2,  32'hDEADBEEF, 32'hA5A5,     32'h55,       0,            4'b1010);
        vecs[14] = mkv(1, 0,  32'h1,        0, 0,            0,  1, 4'h5,  0, 0, 3,  32'h1,        32'h1,        32'hDEADBEEF, 0,            4'b0101);
        vecs[15] = mkv(0, 4,  32'hBAD,      0, 0,            0,  0, 4'h0,  4, 0, 15, 0,            32'h1,        0,            0,            4'b0101);

        RESET = 1'b1;
        Rn_sel = '0; Rm_sel = '0; Rs_sel = '0; Rd_sel = '0;
        in = '0; Pcin = '0; FLAGS_IN = '0;
        clear_ctrl();

        #1;
        check("rst_pc", PCout, 0);
        check("rst_flags", 32'(FLAGS), 0);
        check("rst_rn", Rn, 0);
        check("rst_rm", Rm, 0);
        check("rst_rs", Rs, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        RESET = 1'b0;

        for (int i = 0; i < NV; i++) begin
            LOAD = vecs[i].ld; Rd_sel = vecs[i].rd; in = vecs[i].din;
            LOADPC = vecs[i].lpc; Pcin = vecs[i].pcin; PC_INC = vecs[i].inc;
            FLAGS_LD = vecs[i].fld; FLAGS_IN = vecs[i].fin;
            Rn_sel = vecs[i].rn; Rm_sel = vecs[i].rm; Rs_sel = vecs[i].rs;
            sb.push_back(vecs[i]);
            @(posedge Clk);
            #1;
            clear_ctrl();
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d_rn", i), Rn, e.ern);
            check($sformatf("v%0d_rm", i), Rm, e.erm);
            check($sformatf("v%0d_rs", i), Rs, e.ers);
            check($sformatf("v%0d_pc", i), PCout, e.epc);
            check($sformatf("v%0d_flags", i), 32'(FLAGS), 32'(e.efl));
        end

        // Same-cycle read of a register being written (PC is 0, r5 is 0 here).
        LOAD = 1'b1; Rd_sel = 4'd5; in = 32'h1234; Rn_sel = 4'd5;
        LOADPC = 1'b1; Pcin = 32'h300;
        #1;
`ifdef RF_BYPASS_EN
        check("byp_rn_same", Rn, 32'h1234);
        check("byp_pc_same", PCout, 32'h300);
`else
        check("nobyp_rn_same", Rn, 0);
        check("nobyp_pc_same", PCout, 0);
`endif
        @(posedge Clk);
        #1;
        clear_ctrl();
        #1;
        check("byp_rn_after", Rn, 32'h1234);
        check("byp_pc_after", PCout, 32'h300);

        // Mid-cycle reset while a write and a flag load are pending.
        LOAD = 1'b1; Rd_sel = 4'd6; in = 32'h77;
        FLAGS_LD = 1'b1; FLAGS_IN = 4'hF;
        Rn_sel = 4'd5; Rm_sel = 4'd15; Rs_sel = 4'd3;
        #1;
        RESET = 1'b1;
        #1;
        check("arst_rn", Rn, 0);
        check("arst_rs", Rs, 0);
        check("arst_pc", PCout, 0);
        check("arst_flags", 32'(FLAGS), 0);
        for (int r = 0; r < 16; r++) begin
            Rn_sel = 4'(r);
            #1;
            check($sformatf("arst_r%0d", r), Rn, 0);
        end
        Rn_sel = 4'd6;
        @(posedge Clk);
        #1;
        check("arst_hold_r6", Rn, 0);
        check("arst_hold_flags", 32'(FLAGS), 0);
        RESET = 1'b0;
        @(posedge Clk);
        #1;
        clear_ctrl();
        #1;
        check("post_rst_r6", Rn, 32'h77);
        check("post_rst_flags", 32'(FLAGS), 32'hF);
        check("post_rst_pc", PCout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
